// File: rtl/vga_vram_arbiter.sv
// Frame-buffer RAM scheduler: reserves periodic scan-out fetch slots from the
// 640x480 raster position and round-robins every other cycle between two clients.
module vga_vram_arbiter #(
    parameter int H_RES    = 640,
    parameter int H_MAX    = 800,
    parameter int V_RES    = 480,
    parameter int V_MAX    = 525,
    parameter int WORD_PIX = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c0_gnt,
    output logic              c1_gnt,
    output logic              c0_rvalid,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] cl_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_word,
    output logic              pix_load
);

    localparam int WPL = H_RES / WORD_PIX;
    localparam int LW  = $clog2(WORD_PIX);

    localparam logic [9:0]        H_RES_V    = 10'(H_RES);
    localparam logic [9:0]        H_MAX_V    = 10'(H_MAX);
    localparam logic [9:0]        H_LAST     = 10'(H_MAX - 1);
    localparam logic [9:0]        H_PRE      = 10'(H_MAX - WORD_PIX);
    localparam logic [9:0]        H_SLOT_END = 10'(H_RES - WORD_PIX);
    localparam logic [9:0]        V_RES_V    = 10'(V_RES);
    localparam logic [9:0]        V_MAX_V    = 10'(V_MAX);
    localparam logic [9:0]        V_LAST     = 10'(V_MAX - 1);
    localparam logic [ADDR_W-1:0] WPL_A      = ADDR_W'(WPL);

    typedef enum logic {
        CLIENT0 = 1'b0,
        CLIENT1 = 1'b1
    } client_e;

    client_e           rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] fetch_buf_q, fetch_buf_d;
    logic [DATA_W-1:0] pix_word_q, pix_word_d;
    logic              pix_load_q, pix_load_d;
    logic [DATA_W-1:0] cl_rdata_q, cl_rdata_d;
    logic              c0_rvalid_q, c0_rvalid_d;
    logic              c1_rvalid_q, c1_rvalid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              in_range, slot_a, slot_b, slot, load_next, free;
    logic [9:0]        vnext, next_h, next_v;
    logic [ADDR_W-1:0] slot_addr;

    // Slot (b) prefetches word 0 of the next line so the first word is ready at hpos 0.
    always_comb begin
        in_range  = (hpos < H_MAX_V) && (vpos < V_MAX_V);
        vnext     = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        slot_a    = in_range && (vpos < V_RES_V) && (hpos[LW-1:0] == '0) && (hpos < H_SLOT_END);
        slot_b    = in_range && (hpos == H_PRE) && (vnext < V_RES_V);
        slot      = slot_a || slot_b;
        if (slot_b) begin
            slot_addr = ADDR_W'(vnext) * WPL_A;
        end else begin
            slot_addr = ADDR_W'(vpos) * WPL_A + ADDR_W'(hpos >> LW) + ADDR_W'(1);
        end
        if (hpos == H_LAST) begin
            next_h = 10'd0;
            next_v = vnext;
        end else begin
            next_h = hpos + 10'd1;
            next_v = vpos;
        end
        load_next = in_range && (next_v < V_RES_V) && (next_h < H_RES_V) &&
                    (next_h[LW-1:0] == '0);
    end

    always_comb begin
        free     = !slot && !reset;
        c0_gnt   = free && c0_req && (!c1_req || rr_ptr_q == CLIENT0);
        c1_gnt   = free && c1_req && (!c0_req || rr_ptr_q == CLIENT1);
        rr_ptr_d = rr_ptr_q;
        if (c0_gnt) begin
            rr_ptr_d = CLIENT1;
        end else if (c1_gnt) begin
            rr_ptr_d = CLIENT0;
        end

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = '0;
        if (slot) begin
            mem_en   = 1'b1;
            mem_addr = slot_addr;
        end else if (c0_gnt) begin
            mem_en    = 1'b1;
            mem_we    = c0_we;
            mem_addr  = c0_addr;
            mem_wdata = c0_wdata;
        end else if (c1_gnt) begin
            mem_en    = 1'b1;
            mem_we    = c1_we;
            mem_addr  = c1_addr;
            mem_wdata = c1_wdata;
        end
        mem_addr_d = mem_addr;
    end

    // Read data is captured on the edge closing the access cycle, for both scan-out and clients.
    always_comb begin
        fetch_buf_d = slot ? mem_rdata : fetch_buf_q;
        pix_word_d  = load_next ? fetch_buf_q : pix_word_q;
        pix_load_d  = load_next;
        c0_rvalid_d = c0_gnt && !c0_we;
        c1_rvalid_d = c1_gnt && !c1_we;
        cl_rdata_d  = (c0_rvalid_d || c1_rvalid_d) ? mem_rdata : cl_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= CLIENT0;
            fetch_buf_q <= '0;
            pix_word_q  <= '0;
            pix_load_q  <= 1'b0;
            cl_rdata_q  <= '0;
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            fetch_buf_q <= fetch_buf_d;
            pix_word_q  <= pix_word_d;
            pix_load_q  <= pix_load_d;
            cl_rdata_q  <= cl_rdata_d;
            c0_rvalid_q <= c0_rvalid_d;
            c1_rvalid_q <= c1_rvalid_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign pix_word  = pix_word_q;
    assign pix_load  = pix_load_q;
    assign cl_rdata  = cl_rdata_q;
    assign c0_rvalid = c0_rvalid_q;
    assign c1_rvalid = c1_rvalid_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: drives the raster position directly and
// checks scan-out slots, pixel loads, client arbitration and read responses.
module tb_vga_vram_arbiter;

   localparam int H_MAX = 800;
   localparam int V_MAX = 525;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hpos, vpos;
   logic        c0Req, c0We, c1Req, c1We;
   logic [15:0] c0Addr, c1Addr;
   logic [7:0]  c0Wdata, c1Wdata;
   logic        c0Gnt, c1Gnt, c0Rvalid, c1Rvalid;
   logic [7:0]  clRdata;
   logic        memEn, memWe;
   logic [15:0] memAddr;
   logic [7:0]  memWdata, memRdata;
   logic [7:0]  pixWord;
   logic        pixLoad;

   logic [7:0]  mem [0:65535];

   int assertCount = 0;
   int failCount = 0;

   vga_vram_arbiter dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
      .c0_req(c0Req), .c0_we(c0We), .c0_addr(c0Addr), .c0_wdata(c0Wdata),
      .c1_req(c1Req), .c1_we(c1We), .c1_addr(c1Addr), .c1_wdata(c1Wdata),
      .c0_gnt(c0Gnt), .c1_gnt(c1Gnt), .c0_rvalid(c0Rvalid), .c1_rvalid(c1Rvalid),
      .cl_rdata(clRdata), .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_rdata(memRdata), .pix_word(pixWord), .pix_load(pixLoad)
   );

   // 25 MHz-style pixel clock (period is arbitrary for simulation)
   always #5 clk = ~clk;

   // RAM model: the read word is presented during the access cycle and the
   // arbiter registers it at the closing edge; writes land on that same edge.
   assign memRdata = mem[memAddr];

   // Preload mem[a] = a[7:0], then service writes for the rest of the run
   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
      forever begin
         @(posedge clk);
         if (memEn && memWe) mem[memAddr] <= memWdata;
      end
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Jump the raster position just after a rising edge
   task automatic applyStimulus(input int v, input int h);
      @(posedge clk);
      #1;
      vpos = 10'(v);
      hpos = 10'(h);
   endtask

   // Advance the raster by one pixel clock like the timing generator would
   task automatic advance();
      @(posedge clk);
      #1;
      if (hpos == 10'(H_MAX - 1)) begin
         hpos = 10'd0;
         vpos = (vpos == 10'(V_MAX - 1)) ? 10'd0 : vpos + 10'd1;
      end else begin
         hpos = hpos + 10'd1;
      end
   endtask

   // Outputs are always sampled on the falling edge, away from the active edge
   task automatic sample();
      @(negedge clk);
   endtask

   int   expOwner;
   int   waitC0, waitC1, maxWait;
   logic [1:0] expGnt;

   initial begin
      reset = 1'b1;
      hpos = '0; vpos = '0;
      c0Req = 0; c0We = 0; c0Addr = 16'h0155; c0Wdata = 8'h00;
      c1Req = 0; c1We = 0; c1Addr = 16'h02AA; c1Wdata = 8'h00;

      // Reset held mid-line with both clients requesting; the slot at hpos 296 falls in reset
      applyStimulus(10, 290);
      c0Req = 1; c1Req = 1;
      repeat (10) advance();
      sample();
      checkOutput("rst_c0_gnt", 32'(c0Gnt), 0);
      checkOutput("rst_c1_gnt", 32'(c1Gnt), 0);
      checkOutput("rst_pix_word", 32'(pixWord), 0);
      checkOutput("rst_pix_load", 32'(pixLoad), 0);

      advance();
      reset = 1'b0;
      sample();
      checkOutput("post_rst_first_c0", 32'(c0Gnt), 1);
      checkOutput("post_rst_first_c1", 32'(c1Gnt), 0);
      checkOutput("post_rst_addr", 32'(memAddr), 32'h0155);
      advance();
      sample();
      checkOutput("post_rst_second_c1", 32'(c1Gnt), 1);
      checkOutput("c0_read_rvalid", 32'(c0Rvalid), 1);
      checkOutput("c0_read_data", 32'(clRdata), 32'h55);
      advance();
      sample();
      checkOutput("post_rst_third_c0", 32'(c0Gnt), 1);
      checkOutput("c1_read_rvalid", 32'(c1Rvalid), 1);
      checkOutput("c1_read_data", 32'(clRdata), 32'hAA);
      checkOutput("c0_rvalid_idle", 32'(c0Rvalid), 0);
      advance();
      c0Req = 0; c1Req = 0;
      sample();
      checkOutput("slot304_no_gnt", 32'({c1Gnt, c0Gnt}), 0);
      checkOutput("slot304_addr", 32'(memAddr), 839);
      checkOutput("load304_pulse", 32'(pixLoad), 1);
      checkOutput("load304_word_from_reset", 32'(pixWord), 0);
      repeat (8) advance();
      sample();
      checkOutput("load312_pulse", 32'(pixLoad), 1);
      checkOutput("load312_word", 32'(pixWord), 32'h47);

      // Scan-out addressing on visible line 10
      applyStimulus(10, 0);
      sample();
      checkOutput("slot_v10_h0_addr", 32'(memAddr), 801);
      checkOutput("slot_v10_h0_en", 32'({memEn, memWe}), 2'b10);
      applyStimulus(10, 624);
      sample();
      checkOutput("slot_last_word_addr", 32'(memAddr), 879);
      applyStimulus(10, 632);
      sample();
      checkOutput("no_slot_h632", 32'(memEn), 0);
      applyStimulus(10, 792);
      sample();
      checkOutput("prefetch_v10_addr", 32'(memAddr), 880);
      checkOutput("prefetch_v10_en", 32'(memEn), 1);
      repeat (8) advance();
      sample();
      checkOutput("line11_load", 32'(pixLoad), 1);
      checkOutput("line11_word", 32'(pixWord), 32'h70);
      checkOutput("line11_slot_addr", 32'(memAddr), 881);

      // Frame wrap: no prefetch after the last visible line, prefetch of line 0 at the end of frame
      applyStimulus(479, 792);
      sample();
      checkOutput("no_prefetch_v479", 32'(memEn), 0);
      applyStimulus(524, 792);
      sample();
      checkOutput("prefetch_v524_en", 32'(memEn), 1);
      checkOutput("prefetch_v524_addr", 32'(memAddr), 0);
      repeat (8) advance();
      sample();
      checkOutput("frame_wrap_load", 32'(pixLoad), 1);
      checkOutput("frame_wrap_word", 32'(pixWord), 0);

      // Out-of-range raster position: clients own every cycle
      applyStimulus(10, 900);
      c1Req = 1; c1We = 0; c1Addr = 16'h0077;
      sample();
      checkOutput("oor_h_gnt", 32'(c1Gnt), 1);
      checkOutput("oor_h_addr", 32'(memAddr), 32'h0077);
      applyStimulus(600, 0);
      sample();
      checkOutput("oor_v_gnt", 32'(c1Gnt), 1);
      advance();
      c1Req = 0;

      // Read-after-write by client 1 in vertical blank
      applyStimulus(490, 100);
      c1Req = 1; c1We = 1; c1Addr = 16'h1234; c1Wdata = 8'hA5;
      sample();
      checkOutput("raw_write_gnt", 32'(c1Gnt), 1);
      checkOutput("raw_write_we", 32'(memWe), 1);
      checkOutput("raw_write_addr", 32'(memAddr), 32'h1234);
      checkOutput("raw_write_data", 32'(memWdata), 32'hA5);
      advance();
      c1We = 0;
      sample();
      checkOutput("raw_read_gnt", 32'(c1Gnt), 1);
      checkOutput("raw_read_we", 32'(memWe), 0);
      checkOutput("raw_write_no_rvalid", 32'(c1Rvalid), 0);
      advance();
      c1Req = 0;
      sample();
      checkOutput("raw_rvalid", 32'(c1Rvalid), 1);
      checkOutput("raw_rdata", 32'(clRdata), 32'hA5);
      checkOutput("raw_c0_rvalid", 32'(c0Rvalid), 0);
      checkOutput("idle_mem_en", 32'(memEn), 0);
      checkOutput("idle_addr_hold", 32'(memAddr), 32'h1234);
      advance();
      sample();
      checkOutput("raw_rvalid_pulse_end", 32'(c1Rvalid), 0);

      // Short reset pulse so the round-robin pointer starts at client 0
      applyStimulus(500, 100);
      reset = 1'b1;
      advance();
      reset = 1'b0;

      // Arbitration across visible line 5 with both clients hammering
      applyStimulus(5, 0);
      c0Req = 1; c0We = 0; c0Addr = 16'h0011;
      c1Req = 1; c1We = 0; c1Addr = 16'h0022;
      expOwner = 0; waitC0 = 0; waitC1 = 0; maxWait = 0;
      for (int h = 0; h < 16; h++) begin
         if (h != 0) advance();
         sample();
         if (h % 8 == 0) begin
            expGnt = 2'b00;
         end else begin
            expGnt = (expOwner == 0) ? 2'b01 : 2'b10;
            expOwner = 1 - expOwner;
         end
         checkOutput($sformatf("arb_h%0d_gnt", h), 32'({c1Gnt, c0Gnt}), 32'(expGnt));
         waitC0++; waitC1++;
         if (c0Gnt) begin
            if (waitC0 > maxWait) maxWait = waitC0;
            waitC0 = 0;
         end
         if (c1Gnt) begin
            if (waitC1 > maxWait) maxWait = waitC1;
            waitC1 = 0;
         end
      end
      checkOutput("arb_max_wait_le3", 32'(maxWait <= 3), 1);
      advance();
      c1Req = 0;

      // Blanking throughput: a lone client gets every cycle, including across the line wrap
      applyStimulus(500, 785);
      for (int i = 0; i < 20; i++) begin
         if (i != 0) advance();
         sample();
         checkOutput($sformatf("blank_cyc%0d", i), 32'({c0Gnt, memEn}), 2'b11);
      end
      advance();
      c0Req = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
